// File: rtl/complete_arbiter_if.sv
// Completion-side bundle: FU result requests, branch-resolve broadcast and registered CDB lanes.
// The arbiter takes the slave view; the FUs, branch unit and CDB consumers see the master view.
interface complete_arbiter_if #(
    parameter int N       = 2,
    parameter int NUM_REQ = 4,
    parameter int PRF_W   = 6,
    parameter int DATA_W  = 32,
    parameter int BMASK_W = 4
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0][PRF_W-1:0]   req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0][BMASK_W-1:0] req_b_mask;
    logic [NUM_REQ-1:0]              req_ready;

    logic [BMASK_W-1:0]              b_mm_resolve;
    logic                            b_mm_mispred;

    logic [N-1:0]                    cdb_valid;
    logic [N-1:0][PRF_W-1:0]         cdb_tag;
    logic [N-1:0][DATA_W-1:0]        cdb_data;
    logic [N-1:0][BMASK_W-1:0]       cdb_b_mask;

    modport master (
        output req_valid, req_tag, req_data, req_b_mask, b_mm_resolve, b_mm_mispred,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_b_mask
    );

    modport slave (
        input  req_valid, req_tag, req_data, req_b_mask, b_mm_resolve, b_mm_mispred,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_b_mask
    );
endinterface

// File: rtl/complete_arbiter.sv
// Round-robin completion arbiter: one holding slot per FU, up to N grants per cycle onto registered CDB lanes.
// Result reaches the CDB 2 cycles after accept at best; an FU stalls only while its slot stays occupied and ungranted.
module complete_arbiter #(
    parameter int N       = 2,
    parameter int NUM_REQ = 4,
    parameter int PRF_W   = 6,
    parameter int DATA_W  = 32,
    parameter int BMASK_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    complete_arbiter_if.slave  bus
);
    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [PRF_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
        logic [BMASK_W-1:0] b_mask;
    } res_t;

    logic [NUM_REQ-1:0] occ;
    res_t               slot [NUM_REQ];
    logic [RR_W-1:0]    rr_ptr;
    logic [N-1:0]       cdb_vld_q;
    res_t               cdb_q [N];

    logic [BMASK_W-1:0] clr_mask;
    logic [NUM_REQ-1:0] kill;
    logic [NUM_REQ-1:0] squash_in;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic [N-1:0]       lane_vld_nxt;
    res_t               lane_nxt [N];
    logic [RR_W-1:0]    rr_nxt;

    always_comb begin
        clr_mask  = bus.b_mm_mispred ? '0 : bus.b_mm_resolve;
        kill      = '0;
        squash_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kill[i]      = occ[i] && bus.b_mm_mispred && |(slot[i].b_mask & bus.b_mm_resolve);
            squash_in[i] = bus.b_mm_mispred && |(bus.req_b_mask[i] & bus.b_mm_resolve);
        end
    end

    // Scan from rr_ptr with wrap; the k-th eligible slot found drives lane k.
    always_comb begin : grant_scan
        int cnt;
        int idx;
        cnt          = 0;
        idx          = 0;
        grant        = '0;
        lane_vld_nxt = '0;
        rr_nxt       = rr_ptr;
        for (int l = 0; l < N; l++) lane_nxt[l] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (occ[idx] && !kill[idx] && cnt < N) begin
                grant[idx]               = 1'b1;
                lane_vld_nxt[cnt]        = 1'b1;
                lane_nxt[cnt].tag        = slot[idx].tag;
                lane_nxt[cnt].data       = slot[idx].data;
                lane_nxt[cnt].b_mask     = slot[idx].b_mask & ~clr_mask;
                rr_nxt                   = RR_W'((idx + 1) % NUM_REQ);
                cnt                      = cnt + 1;
            end
        end
    end

    assign bus.req_ready = {NUM_REQ{!reset}} & (~occ | grant | kill);
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            occ       <= '0;
            rr_ptr    <= '0;
            cdb_vld_q <= '0;
            for (int l = 0; l < N; l++) cdb_q[l] <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            cdb_vld_q <= lane_vld_nxt;
            for (int l = 0; l < N; l++) cdb_q[l] <= lane_nxt[l];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    // A squashed arrival is still consumed so the FU can move on.
                    occ[i]         <= !squash_in[i];
                    slot[i].tag    <= bus.req_tag[i];
                    slot[i].data   <= bus.req_data[i];
                    slot[i].b_mask <= bus.req_b_mask[i] & ~clr_mask;
                end else begin
                    if (grant[i] || kill[i]) occ[i] <= 1'b0;
                    slot[i].b_mask <= slot[i].b_mask & ~clr_mask;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < N; l++) begin
            bus.cdb_tag[l]    = cdb_q[l].tag;
            bus.cdb_data[l]   = cdb_q[l].data;
            bus.cdb_b_mask[l] = cdb_q[l].b_mask;
        end
    end
    assign bus.cdb_valid = cdb_vld_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter: directed scenarios followed by a long randomized run, all against a queue-based reference model.
module tb_complete_arbiter;
    localparam int N       = 2;
    localparam int NREQ    = 4;
    localparam int PRF_W   = 6;
    localparam int DATA_W  = 32;
    localparam int BMASK_W = 4;

    logic clock;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    complete_arbiter_if #(.N(N), .NUM_REQ(NREQ), .PRF_W(PRF_W), .DATA_W(DATA_W), .BMASK_W(BMASK_W)) bus ();

    complete_arbiter #(.N(N), .NUM_REQ(NREQ), .PRF_W(PRF_W), .DATA_W(DATA_W), .BMASK_W(BMASK_W)) dut (
        .clock (clock),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // reference model state
    bit                 m_occ  [NREQ];
    logic [PRF_W-1:0]   m_tag  [NREQ];
    logic [DATA_W-1:0]  m_data [NREQ];
    logic [BMASK_W-1:0] m_mask [NREQ];
    int                 m_rr;
    logic [N-1:0]       e_vld;
    logic [PRF_W-1:0]   e_tag  [N];
    logic [DATA_W-1:0]  e_data [N];
    logic [BMASK_W-1:0] e_mask [N];

    logic [NREQ-1:0]    rdy_seen;
    logic [NREQ-1:0]    last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic tick();
        int              gl[$];
        bit              gbit [NREQ];
        logic [NREQ-1:0] kl;
        logic [NREQ-1:0] exp_rdy;
        logic [BMASK_W-1:0] clr;
        logic [BMASK_W-1:0] res;
        bit              mis;
        #1;
        res = bus.b_mm_resolve;
        mis = bus.b_mm_mispred;
        clr = mis ? '0 : res;
        for (int i = 0; i < NREQ; i++) begin
            kl[i]   = m_occ[i] && mis && ((m_mask[i] & res) != 0);
            gbit[i] = 0;
        end
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (m_occ[idx] && !kl[idx] && gl.size() < N) begin
                gl.push_back(idx);
                gbit[idx] = 1;
            end
        end
        for (int i = 0; i < NREQ; i++)
            exp_rdy[i] = !rst && (!m_occ[i] || gbit[i] || kl[i]);

        chk("ready", bus.req_ready, exp_rdy);
        chk("cdb_valid", bus.cdb_valid, e_vld);
        for (int l = 0; l < N; l++) begin
            chk("cdb_tag", bus.cdb_tag[l], e_tag[l]);
            chk("cdb_data", bus.cdb_data[l], e_data[l]);
            chk("cdb_mask", bus.cdb_b_mask[l], e_mask[l]);
        end
        rdy_seen = bus.req_ready;
        last_acc = bus.req_valid & exp_rdy;

        if (rst) begin
            for (int i = 0; i < NREQ; i++) m_occ[i] = 0;
            m_rr  = 0;
            e_vld = '0;
            for (int l = 0; l < N; l++) begin
                e_tag[l] = '0; e_data[l] = '0; e_mask[l] = '0;
            end
        end else begin
            e_vld = '0;
            for (int l = 0; l < N; l++) begin
                e_tag[l] = '0; e_data[l] = '0; e_mask[l] = '0;
            end
            for (int j = 0; j < gl.size(); j++) begin
                e_vld[j]  = 1'b1;
                e_tag[j]  = m_tag[gl[j]];
                e_data[j] = m_data[gl[j]];
                e_mask[j] = m_mask[gl[j]] & ~clr;
            end
            if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && exp_rdy[i]) begin
                    m_occ[i]  = !(mis && ((bus.req_b_mask[i] & res) != 0));
                    m_tag[i]  = bus.req_tag[i];
                    m_data[i] = bus.req_data[i];
                    m_mask[i] = bus.req_b_mask[i] & ~clr;
                end else if (gbit[i] || kl[i]) begin
                    m_occ[i] = 0;
                end else begin
                    m_mask[i] = m_mask[i] & ~clr;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.req_valid    = '0;
        bus.b_mm_resolve = '0;
        bus.b_mm_mispred = 1'b0;
    endtask

    task automatic drive_req(input int i, input logic [PRF_W-1:0] t,
                             input logic [DATA_W-1:0] d, input logic [BMASK_W-1:0] m);
        bus.req_valid[i]  = 1'b1;
        bus.req_tag[i]    = t;
        bus.req_data[i]   = d;
        bus.req_b_mask[i] = m;
    endtask

    task automatic drive_all4();
        for (int i = 0; i < NREQ; i++)
            drive_req(i, PRF_W'(8 + i), DATA_W'(32'h111 * i), '0);
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_tag      = '0;
        bus.req_data     = '0;
        bus.req_b_mask   = '0;
        bus.b_mm_resolve = '0;
        bus.b_mm_mispred = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            m_occ[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_mask[i] = '0;
        end
        m_rr  = 0;
        e_vld = '0;
        for (int l = 0; l < N; l++) begin
            e_tag[l] = '0; e_data[l] = '0; e_mask[l] = '0;
        end
        last_acc = '0;
        @(negedge clock);
        tick();
        rst = 1'b0;

        // reset with slots 0 and 2 occupied
        drive_req(0, 6'd1, 32'hA0, '0);
        drive_req(2, 6'd3, 32'hA2, '0);
        tick();
        pulse_reset();
        chk("rst_cdb", bus.cdb_valid, 2'b00);
        tick();
        chk("rst_ready", rdy_seen, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_stale", bus.cdb_valid, 2'b00);
        end

        // single request from FU 1
        drive_req(1, 6'd5, 32'hDEADBEEF, 4'b0000);
        tick();
        idle_inputs();
        tick();
        chk("single_vld", bus.cdb_valid, 2'b01);
        chk("single_tag", bus.cdb_tag[0], 6'd5);
        chk("single_data", bus.cdb_data[0], 32'hDEADBEEF);
        // rr_ptr now 2: a full burst should be served 2,3 then 0,1
        drive_all4();
        tick();
        idle_inputs();
        tick();
        chk("rr2_lane0", bus.cdb_tag[0], 6'd10);
        chk("rr2_lane1", bus.cdb_tag[1], 6'd11);
        tick();
        chk("rr2_wrap0", bus.cdb_tag[0], 6'd8);
        chk("rr2_wrap1", bus.cdb_tag[1], 6'd9);

        // contention from rr_ptr=0
        pulse_reset();
        drive_all4();
        tick();
        idle_inputs();
        tick();
        chk("cont_ready", rdy_seen, 4'b0011);
        chk("cont_c2_l0", bus.cdb_tag[0], 6'd8);
        chk("cont_c2_l1", bus.cdb_tag[1], 6'd9);
        tick();
        chk("cont_c3_l0", bus.cdb_tag[0], 6'd10);
        chk("cont_c3_l1", bus.cdb_tag[1], 6'd11);
        drive_all4();
        tick();
        idle_inputs();
        tick();
        chk("cont_rr0", bus.cdb_tag[0], 6'd8);
        tick();

        // fairness: FUs 0 and 3 always valid, both must drain every cycle
        drive_req(0, 6'd30, 32'h30, '0);
        drive_req(3, 6'd33, 32'h33, '0);
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("fair_vld", bus.cdb_valid, 2'b11);
            chk("fair_ready", rdy_seen, 4'b1111);
        end
        idle_inputs();
        tick();
        tick();

        // mispredict kills slot 2 and the incoming request on FU 0
        drive_req(1, 6'd11, 32'h1111, 4'b0100);
        drive_req(2, 6'd12, 32'h2222, 4'b0010);
        tick();
        idle_inputs();
        drive_req(0, 6'd13, 32'h3333, 4'b0010);
        bus.b_mm_resolve = 4'b0010;
        bus.b_mm_mispred = 1'b1;
        tick();
        chk("mis_ready0", rdy_seen[0], 1'b1);
        chk("mis_vld", bus.cdb_valid, 2'b01);
        chk("mis_tag", bus.cdb_tag[0], 6'd11);
        chk("mis_mask", bus.cdb_b_mask[0], 4'b0100);
        idle_inputs();
        tick();
        chk("mis_gone", bus.cdb_valid, 2'b00);
        tick();
        chk("mis_gone2", bus.cdb_valid, 2'b00);

        // correct resolve clears bit 0 on the way out
        drive_req(3, 6'd20, 32'h2020, 4'b0011);
        tick();
        idle_inputs();
        bus.b_mm_resolve = 4'b0001;
        tick();
        chk("cr_vld", bus.cdb_valid, 2'b01);
        chk("cr_tag", bus.cdb_tag[0], 6'd20);
        chk("cr_mask", bus.cdb_b_mask[0], 4'b0010);
        idle_inputs();
        tick();

        // randomized run; FUs hold their result until the model says it was taken
        last_acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || last_acc[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        drive_req(i, PRF_W'($urandom), $urandom, BMASK_W'($urandom));
                    else
                        bus.req_valid[i] = 1'b0;
                end
            end
            case ($urandom_range(0, 7))
                0: bus.b_mm_resolve = 4'b0001;
                1: bus.b_mm_resolve = 4'b0010;
                2: bus.b_mm_resolve = 4'b0100;
                3: bus.b_mm_resolve = 4'b1000;
                default: bus.b_mm_resolve = 4'b0000;
            endcase
            bus.b_mm_mispred = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
